mngr_src_sink: RTL

//  Synthesizable test manager: the far end of the processor's mngr2proc/proc2mngr
//  val/rdy streams. Streams a programmed list of 32b words into the processor and

---
 rtl/mngr_pkg.sv | 12 +
 rtl/mngr_table.sv | 22 ++
 rtl/mngr_src_sink.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/mngr_pkg.sv
// Shared types and constants for the mngr source/sink test manager.
package mngr_pkg;
   typedef enum logic [1:0] {IDLE, RUN, DONE} mngr_state_e;

   localparam int         MNGR_MSG_W     = 32;
   localparam logic [7:0] MNGR_LFSR_SEED = 8'hA5;

   // Maximal-length 8b Fibonacci LFSR, taps 8,6,5,4.
   function automatic logic [7:0] lfsr_next(input logic [7:0] s);
      return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
   endfunction
endpackage

// File: rtl/mngr_table.sv
// DEPTH x 32b register file: one synchronous write port, one asynchronous read port.
module mngr_table
   import mngr_pkg::*;
#(
   parameter int DEPTH = 64,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  we_i,
   input  logic [AW-1:0]         waddr_i,
   input  logic [MNGR_MSG_W-1:0] wdata_i,
   input  logic [AW-1:0]         raddr_i,
   output logic [MNGR_MSG_W-1:0] rdata_o
);
   logic [MNGR_MSG_W-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
   end

   assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/mngr_src_sink.sv
// Test manager: streams a programmed word list into the processor and checks
// every word it returns against an expected list, reporting pass/fail.
module mngr_src_sink
   import mngr_pkg::*;
#(
   parameter int DEPTH    = 64,
   parameter int AW       = $clog2(DEPTH),
   parameter bit STALL_EN = 1'b0,
   parameter int TIMEOUT  = 4000
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  cfg_we,
   input  logic                  cfg_sel,
   input  logic [AW-1:0]         cfg_addr,
   input  logic [MNGR_MSG_W-1:0] cfg_data,
   input  logic [AW:0]           src_count,
   input  logic [AW:0]           sink_count,
   input  logic                  start,
   output logic [MNGR_MSG_W-1:0] mngr2proc_msg,
   output logic                  mngr2proc_val,
   input  logic                  mngr2proc_rdy,
   input  logic [MNGR_MSG_W-1:0] proc2mngr_msg,
   input  logic                  proc2mngr_val,
   output logic                  proc2mngr_rdy,
   output logic                  done,
   output logic                  pass,
   output logic [AW:0]           err_count,
   output logic                  error_timeout,
   output logic [AW-1:0]         first_err_idx,
   output logic [MNGR_MSG_W-1:0] first_err_data
);
   localparam int              TW       = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0]   TMO_LAST = TW'(TIMEOUT - 1);
   localparam logic [AW:0]     DEPTH_C  = DEPTH[AW:0];
   localparam logic [AW:0]     ERR_MAX  = '1;

   mngr_state_e           state_q, state_d;
   logic [AW:0]           src_idx_q, src_idx_d, sink_idx_q, sink_idx_d;
   logic [AW:0]           src_cnt_q, src_cnt_d, sink_cnt_q, sink_cnt_d;
   logic [AW:0]           err_cnt_q, err_cnt_d;
   logic [AW-1:0]         ferr_idx_q, ferr_idx_d;
   logic [MNGR_MSG_W-1:0] ferr_data_q, ferr_data_d;
   logic                  err_tmo_q, err_tmo_d, done_q, done_d, pass_q, pass_d;
   logic                  src_hold_q, src_hold_d;
   logic [TW-1:0]         tmo_q, tmo_d;
   logic [7:0]            lfsr_q;
   logic [MNGR_MSG_W-1:0] src_rdata, sink_rdata;
   logic                  in_run, stall_src, stall_sink, src_val, sink_rdy;
   logic                  src_xfer, sink_xfer;

   function automatic logic [AW:0] clamp_cnt(input logic [AW:0] c);
      return (c > DEPTH_C) ? DEPTH_C : c;
   endfunction

   mngr_table #(.DEPTH(DEPTH), .AW(AW)) u_src_tab (
      .clk     (clk),
      .we_i    (cfg_we && !cfg_sel && !in_run),
      .waddr_i (cfg_addr),
      .wdata_i (cfg_data),
      .raddr_i (src_idx_q[AW-1:0]),
      .rdata_o (src_rdata)
   );

   mngr_table #(.DEPTH(DEPTH), .AW(AW)) u_sink_tab (
      .clk     (clk),
      .we_i    (cfg_we && cfg_sel && !in_run),
      .waddr_i (cfg_addr),
      .wdata_i (cfg_data),
      .raddr_i (sink_idx_q[AW-1:0]),
      .rdata_o (sink_rdata)
   );

   // A raised source valid is held until it transfers; bubbles only delay raising it.
   always_comb begin
      in_run     = (state_q == RUN);
      stall_src  = STALL_EN && (lfsr_q[1:0] == 2'b00) && !src_hold_q;
      stall_sink = STALL_EN && (lfsr_q[3:2] == 2'b00);
      src_val    = in_run && (src_idx_q < src_cnt_q) && !stall_src;
      sink_rdy   = in_run && (sink_idx_q < sink_cnt_q) && !stall_sink;
      src_xfer   = src_val && mngr2proc_rdy;
      sink_xfer  = sink_rdy && proc2mngr_val;
   end

   always_comb begin
      state_d     = state_q;
      src_idx_d   = src_idx_q;
      sink_idx_d  = sink_idx_q;
      src_cnt_d   = src_cnt_q;
      sink_cnt_d  = sink_cnt_q;
      err_cnt_d   = err_cnt_q;
      ferr_idx_d  = ferr_idx_q;
      ferr_data_d = ferr_data_q;
      err_tmo_d   = err_tmo_q;
      done_d      = done_q;
      pass_d      = pass_q;
      tmo_d       = tmo_q;
      src_hold_d  = src_val && !mngr2proc_rdy;
      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d     = RUN;
               src_idx_d   = '0;
               sink_idx_d  = '0;
               src_cnt_d   = clamp_cnt(src_count);
               sink_cnt_d  = clamp_cnt(sink_count);
               err_cnt_d   = '0;
               ferr_idx_d  = '0;
               ferr_data_d = '0;
               err_tmo_d   = 1'b0;
               done_d      = 1'b0;
               pass_d      = 1'b0;
               tmo_d       = '0;
               if (clamp_cnt(sink_count) == '0) begin
                  state_d = DONE;
                  done_d  = 1'b1;
                  pass_d  = 1'b1;
               end
            end
         end
         RUN: begin
            if (src_xfer) src_idx_d = src_idx_q + 1'b1;
            if (sink_xfer) begin
               sink_idx_d = sink_idx_q + 1'b1;
               if (proc2mngr_msg != sink_rdata) begin
                  if (err_cnt_q == '0) begin
                     ferr_idx_d  = sink_idx_q[AW-1:0];
                     ferr_data_d = proc2mngr_msg;
                  end
                  if (err_cnt_q != ERR_MAX) err_cnt_d = err_cnt_q + 1'b1;
               end
            end
            tmo_d = (src_xfer || sink_xfer) ? '0 : tmo_q + 1'b1;
            if (sink_idx_d == sink_cnt_q) begin
               state_d = DONE;
               done_d  = 1'b1;
               pass_d  = (err_cnt_d == '0);
            end else if (!(src_xfer || sink_xfer) && (tmo_q == TMO_LAST)) begin
               state_d   = DONE;
               done_d    = 1'b1;
               err_tmo_d = 1'b1;
               pass_d    = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         src_idx_q   <= '0;
         sink_idx_q  <= '0;
         src_cnt_q   <= '0;
         sink_cnt_q  <= '0;
         err_cnt_q   <= '0;
         ferr_idx_q  <= '0;
         ferr_data_q <= '0;
         err_tmo_q   <= 1'b0;
         done_q      <= 1'b0;
         pass_q      <= 1'b0;
         tmo_q       <= '0;
         src_hold_q  <= 1'b0;
         lfsr_q      <= MNGR_LFSR_SEED;
      end else begin
         state_q     <= state_d;
         src_idx_q   <= src_idx_d;
         sink_idx_q  <= sink_idx_d;
         src_cnt_q   <= src_cnt_d;
         sink_cnt_q  <= sink_cnt_d;
         err_cnt_q   <= err_cnt_d;
         ferr_idx_q  <= ferr_idx_d;
         ferr_data_q <= ferr_data_d;
         err_tmo_q   <= err_tmo_d;
         done_q      <= done_d;
         pass_q      <= pass_d;
         tmo_q       <= tmo_d;
         src_hold_q  <= src_hold_d;
         lfsr_q      <= lfsr_next(lfsr_q);
      end
   end

   assign mngr2proc_val  = src_val;
   assign mngr2proc_msg  = src_val ? src_rdata : '0;
   assign proc2mngr_rdy  = sink_rdy;
   assign done           = done_q;
   assign pass           = pass_q;
   assign err_count      = err_cnt_q;
   assign error_timeout  = err_tmo_q;
   assign first_err_idx  = ferr_idx_q;
   assign first_err_data = ferr_data_q;
endmodule
